// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller.
// The MASK_* macros follow the shared defines.sv encodings and are only defined here if absent.
`ifndef MASK_WIDTH
`define MASK_WIDTH 2
`define MASK_B 2'b00
`define MASK_H 2'b01
`define MASK_W 2'b10
`endif

package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LD_WAIT = 2'd1,
    RMW_RD  = 2'd2,
    RMW_WR  = 2'd3
  } state_t;

  localparam logic [`MASK_WIDTH-1:0] MSK_B = `MASK_B;
  localparam logic [`MASK_WIDTH-1:0] MSK_H = `MASK_H;
  localparam logic [`MASK_WIDTH-1:0] MSK_W = `MASK_W;

  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  // Flags conflicting requests, unaligned half/word accesses and unknown masks.
  function automatic logic misalign_chk(input logic rd, input logic wr,
                                        input logic [`MASK_WIDTH-1:0] mask,
                                        input logic [1:0] addr_lo);
    logic err;
    err = rd & wr;
    case (mask)
      MSK_B:   err = err;
      MSK_H:   err = err | addr_lo[0];
      MSK_W:   err = err | (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: load extract/extend, store merge and (DMEM_BYTE_EN_EN)
// byte-enable plus lane replication for a byte-enabled RAM.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [`MASK_WIDTH-1:0] mask,
  input  logic [1:0]             addr_lo,
  input  logic                   is_unsigned,
  input  logic [DATA_W-1:0]      rdata,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      ld_data,
  output logic [DATA_W-1:0]      merged
`ifdef DMEM_BYTE_EN_EN
  ,
  output logic [3:0]             be,
  output logic [DATA_W-1:0]      rep_wdata
`endif
);

  logic signed [7:0]  ld_byte;
  logic signed [15:0] ld_half;

  always_comb begin
    ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase

    case (mask)
      MSK_B:   ld_data = is_unsigned ? DATA_W'($unsigned(ld_byte)) : DATA_W'(ld_byte);
      MSK_H:   ld_data = is_unsigned ? DATA_W'($unsigned(ld_half)) : DATA_W'(ld_half);
      default: ld_data = rdata;
    endcase
  end

  // Old word with the addressed lane replaced; a word mask simply passes the new data.
  always_comb begin
    merged = rdata;
    case (mask)
      MSK_B: begin
        case (addr_lo)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      MSK_H: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

`ifdef DMEM_BYTE_EN_EN
  always_comb begin
    be        = BE_ALL;
    rep_wdata = wdata;
    case (mask)
      MSK_B: begin
        be        = BE_BYTE0 << addr_lo;
        rep_wdata = {4{wdata[7:0]}};
      end
      MSK_H: begin
        be        = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        rep_wdata = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the MEM stage and a 1-cycle-latency word RAM.
// Define DMEM_BYTE_EN_EN for a byte-enabled RAM; otherwise sub-word stores use read-modify-write.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int WORD_ADDR_W = 12,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_rd,
  input  logic                   req_wr,
  input  logic [31:0]            req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [`MASK_WIDTH-1:0] req_mask,
  input  logic                   req_unsigned,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   stall,
  output logic                   misalign,
  output logic                   ram_en,
  output logic                   ram_we,
  output logic [WORD_ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0]      ram_wdata,
`ifdef DMEM_BYTE_EN_EN
  output logic [3:0]             ram_be,
`endif
  input  logic [DATA_W-1:0]      ram_rdata
);

  state_t                 state, state_nx;
  logic [DATA_W-1:0]      wbuf;
  logic [DATA_W-1:0]      ld_data;
  logic [DATA_W-1:0]      merged;
  logic                   req_any;
  logic                   req_err;
  logic [WORD_ADDR_W-1:0] word_addr;
  logic                   unused_addr;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]             lane_be;
  logic [DATA_W-1:0]      rep_wdata;
`endif

  assign req_any     = req_rd | req_wr;
  assign req_err     = misalign_chk(req_rd, req_wr, req_mask, req_addr[1:0]);
  assign word_addr   = req_addr[WORD_ADDR_W+1:2];
  assign unused_addr = &{1'b0, req_addr[31:WORD_ADDR_W+2]};

  dmem_lane_align #(
    .DATA_W(DATA_W)
  ) u_lane (
    .mask       (req_mask),
    .addr_lo    (req_addr[1:0]),
    .is_unsigned(req_unsigned),
    .rdata      (ram_rdata),
    .wdata      (req_wdata),
    .ld_data    (ld_data),
    .merged     (merged)
`ifdef DMEM_BYTE_EN_EN
    ,
    .be         (lane_be),
    .rep_wdata  (rep_wdata)
`endif
  );

  // State register; wbuf captures the merged word while the RMW read data is on ram_rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wbuf  <= '0;
    end else begin
      state <= state_nx;
      if (state == RMW_RD) wbuf <= merged;
    end
  end

  always_comb begin
    state_nx  = state;
    rd_data   = '0;
    rd_valid  = 1'b0;
    stall     = 1'b0;
    misalign  = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
`ifdef DMEM_BYTE_EN_EN
    ram_be    = '0;
`endif
    case (state)
      IDLE: begin
        if (req_any) begin
          if (req_err) begin
            misalign = 1'b1;
          end else begin
            ram_en   = 1'b1;
            ram_addr = word_addr;
            if (req_rd) begin
              stall    = 1'b1;
              state_nx = LD_WAIT;
            end
`ifdef DMEM_BYTE_EN_EN
            else begin
              ram_we    = 1'b1;
              ram_wdata = rep_wdata;
              ram_be    = lane_be;
            end
`else
            else if (req_mask == MSK_W) begin
              ram_we    = 1'b1;
              ram_wdata = req_wdata;
            end else begin
              stall    = 1'b1;
              state_nx = RMW_RD;
            end
`endif
          end
        end
      end
      LD_WAIT: begin
        rd_valid = 1'b1;
        rd_data  = ld_data;
        state_nx = IDLE;
      end
      RMW_RD: begin
        stall    = 1'b1;
        state_nx = RMW_WR;
      end
      RMW_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = word_addr;
        ram_wdata = wbuf;
`ifdef DMEM_BYTE_EN_EN
        ram_be    = BE_ALL;
`endif
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Outputs must read zero throughout reset even if the request lines are active.
    if (rst) begin
      rd_data   = '0;
      rd_valid  = 1'b0;
      stall     = 1'b0;
      misalign  = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
`ifdef DMEM_BYTE_EN_EN
      ram_be    = '0;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: behavioural RAM, byte-array reference model, directed and random accesses.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int WAW = 12;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   req_rd, req_wr, req_unsigned;
  logic [31:0]            req_addr, req_wdata;
  logic [`MASK_WIDTH-1:0] req_mask;
  logic [31:0]            rd_data, ram_wdata;
  logic                   rd_valid, stall, misalign, ram_en, ram_we;
  logic [WAW-1:0]         ram_addr;
  logic [31:0]            ram_rdata;
`ifdef DMEM_BYTE_EN_EN
  logic [3:0]             ram_be;
  localparam bit BE_BUILD = 1'b1;
`else
  localparam bit BE_BUILD = 1'b0;
`endif

  logic [31:0] mem [0:(1<<WAW)-1];
  logic [7:0]  ref_mem [0:255];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.WORD_ADDR_W(WAW), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_mask(req_mask), .req_unsigned(req_unsigned),
    .rd_data(rd_data), .rd_valid(rd_valid), .stall(stall), .misalign(misalign),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
`ifdef DMEM_BYTE_EN_EN
    .ram_be(ram_be),
`endif
    .ram_rdata(ram_rdata)
  );

  // Synchronous single-port RAM with 1-cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
`ifdef DMEM_BYTE_EN_EN
        for (int i = 0; i < 4; i++)
          if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
`else
        mem[ram_addr] <= ram_wdata;
`endif
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  // Request lines must hold while stall is high
  logic                   p_stall = 1'b0;
  logic                   p_rd, p_wr, p_uns;
  logic [31:0]            p_addr, p_wdata;
  logic [`MASK_WIDTH-1:0] p_mask;
  always @(negedge clk) begin
    if (!rst && p_stall)
      assert (req_rd == p_rd && req_wr == p_wr && req_addr == p_addr &&
              req_wdata == p_wdata && req_mask == p_mask && req_unsigned == p_uns)
        else $error("protocol violation: request changed while stall was high");
    p_stall <= stall && !rst;
    p_rd    <= req_rd;
    p_wr    <= req_wr;
    p_addr  <= req_addr;
    p_wdata <= req_wdata;
    p_mask  <= req_mask;
    p_uns   <= req_unsigned;
  end

  function automatic int size_of(input logic [`MASK_WIDTH-1:0] m);
    return (m == MSK_B) ? 1 : (m == MSK_H) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [`MASK_WIDTH-1:0] m,
                                           input logic u);
    int n;
    logic [31:0] v;
    n = size_of(m);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a[7:0]) + i];
    if (!u && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [`MASK_WIDTH-1:0] m,
                           input logic [31:0] d);
    for (int i = 0; i < size_of(m); i++) ref_mem[int'(a[7:0]) + i] = d[8*i +: 8];
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    req_mask = MSK_W; req_unsigned = 1'b0;
  endtask

  // One access from acceptance to completion, checked against the reference model.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [`MASK_WIDTH-1:0] mask,
                        input logic uns, input string name, output logic [31:0] dout);
    int stalls, wrs, cyc, exp_stalls;
    logic mis, got_valid, exp_err, bad_en, bad_addr;
    logic [31:0] exp_data;
    stalls = 0; wrs = 0; cyc = 0; mis = 1'b0; got_valid = 1'b0;
    bad_en = 1'b0; bad_addr = 1'b0; dout = '0;
    exp_err = (rd && wr) || (mask != MSK_B && mask != MSK_H && mask != MSK_W) ||
              (mask == MSK_H && addr[0]) || (mask == MSK_W && addr[1:0] != 2'b00);
    exp_stalls = exp_err ? 0 : rd ? 1 : (mask == MSK_W || BE_BUILD) ? 0 : 2;
    exp_data = rd ? ref_load(addr, mask, uns) : 32'h0;

    @(posedge clk); #1;
    req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wdata;
    req_mask = mask; req_unsigned = uns;
    forever begin
      @(negedge clk);
      cyc++;
      if (misalign) mis = 1'b1;
      if (stall) stalls++;
      if (ram_en && ram_we) wrs++;
      if (ram_en && exp_err) bad_en = 1'b1;
      if (ram_en && ram_addr !== addr[WAW+1:2]) bad_addr = 1'b1;
      if (rd_valid) begin got_valid = 1'b1; dout = rd_data; end
      if (!rd_valid && rd_data !== 32'h0) begin
        n_tests++; n_fail++;
        $display("FAIL %s rd_data_idle got %h want 00000000", name, rd_data);
      end
      if (!stall || cyc >= 6) break;
    end

    n_tests++;
    if (stall) begin n_fail++; $display("FAIL %s timeout stall still high after %0d cycles", name, cyc); end
    n_tests++;
    if (mis !== exp_err) begin n_fail++; $display("FAIL %s misalign got %0b want %0b", name, mis, exp_err); end
    n_tests++;
    if (stalls != exp_stalls) begin n_fail++; $display("FAIL %s stall_cycles got %0d want %0d", name, stalls, exp_stalls); end
    n_tests++;
    if (wrs != ((wr && !exp_err) ? 1 : 0)) begin
      n_fail++; $display("FAIL %s ram_writes got %0d want %0d", name, wrs, (wr && !exp_err) ? 1 : 0);
    end
    n_tests++;
    if (bad_en || bad_addr) begin n_fail++; $display("FAIL %s ram_en/addr got bad_en=%0b bad_addr=%0b want 0/0", name, bad_en, bad_addr); end
    n_tests++;
    if (got_valid !== (rd && !exp_err)) begin
      n_fail++; $display("FAIL %s rd_valid got %0b want %0b", name, got_valid, rd && !exp_err);
    end else if (got_valid && dout !== exp_data) begin
      n_fail++; $display("FAIL %s rd_data got %h want %h", name, dout, exp_data);
    end
    if (wr && !rd && !exp_err) ref_store(addr, mask, wdata);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_rd = 1'b1; req_wr = 1'b0; req_addr = 32'h10; req_wdata = 32'h12345678;
    req_mask = MSK_W; req_unsigned = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({stall, misalign, rd_valid, ram_en, ram_we} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 00000", {stall, misalign, rd_valid, ram_en, ram_we});
    end
    n_tests++;
    if (rd_data !== 32'h0 || ram_addr !== '0 || ram_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_data got rd=%h addr=%h wd=%h want 0", rd_data, ram_addr, ram_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_rd = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    n_tests++;
    if ({stall, rd_valid, ram_en, ram_we} !== 4'b0 || ram_addr !== '0 || ram_wdata !== 32'h0 || rd_data !== 32'h0) begin
      n_fail++; $display("FAIL idle_outputs got en=%0b we=%0b addr=%h wd=%h want all 0", ram_en, ram_we, ram_addr, ram_wdata);
    end
  endtask

  task automatic init_mem();
    logic [31:0] d;
    for (int w = 0; w < 64; w++) access(1'b0, 1'b1, 32'(w * 4), 32'h0, MSK_W, 1'b0, "init_sw", d);
    go_idle();
  endtask

  task automatic test_word();
    logic [31:0] d;
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, MSK_W, 1'b0, "sw_10", d);
    go_idle();
    access(1'b1, 1'b0, 32'h10, 32'h0, MSK_W, 1'b0, "lw_10", d);
    n_tests++;
    if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_10_const got %h want deadbeef", d); end
    go_idle();
  endtask

  task automatic test_byte_rmw();
    logic [31:0] d;
    access(1'b0, 1'b1, 32'h20, 32'h11223344, MSK_W, 1'b0, "sw_20", d);
    access(1'b0, 1'b1, 32'h22, 32'h000000AA, MSK_B, 1'b0, "sb_22", d);
    access(1'b1, 1'b0, 32'h20, 32'h0, MSK_W, 1'b0, "lw_20_after_sb", d);
    n_tests++;
    if (d !== 32'h11AA3344) begin n_fail++; $display("FAIL sb_merge got %h want 11aa3344", d); end
    access(1'b1, 1'b0, 32'h22, 32'h0, MSK_B, 1'b1, "lbu_22", d);
    n_tests++;
    if (d !== 32'h000000AA) begin n_fail++; $display("FAIL lbu_22_const got %h want 000000aa", d); end
    access(1'b1, 1'b0, 32'h22, 32'h0, MSK_B, 1'b0, "lb_22", d);
    n_tests++;
    if (d !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL lb_22_const got %h want ffffffaa", d); end
    go_idle();
  endtask

  task automatic test_half_rmw();
    logic [31:0] d;
    access(1'b0, 1'b1, 32'h1C, 32'h11223344, MSK_W, 1'b0, "sw_1c", d);
    access(1'b0, 1'b1, 32'h1E, 32'h00008001, MSK_H, 1'b0, "sh_1e", d);
    access(1'b1, 1'b0, 32'h1C, 32'h0, MSK_W, 1'b0, "lw_1c_after_sh", d);
    n_tests++;
    if (d !== 32'h80013344) begin n_fail++; $display("FAIL sh_merge got %h want 80013344", d); end
    access(1'b1, 1'b0, 32'h1E, 32'h0, MSK_H, 1'b0, "lh_1e", d);
    n_tests++;
    if (d !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_1e_const got %h want ffff8001", d); end
    access(1'b1, 1'b0, 32'h1E, 32'h0, MSK_H, 1'b1, "lhu_1e", d);
    n_tests++;
    if (d !== 32'h00008001) begin n_fail++; $display("FAIL lhu_1e_const got %h want 00008001", d); end
    go_idle();
  endtask

  task automatic test_misalign();
    logic [31:0] d;
    access(1'b1, 1'b0, 32'h13, 32'h0, MSK_W, 1'b0, "lw_13_mis", d);
    access(1'b0, 1'b1, 32'h21, 32'h0000FFFF, MSK_H, 1'b0, "sh_21_mis", d);
    access(1'b1, 1'b1, 32'h20, 32'h0, MSK_W, 1'b0, "rd_wr_both", d);
    access(1'b0, 1'b1, 32'h20, 32'h0, 2'b11, 1'b0, "bad_mask", d);
    access(1'b1, 1'b0, 32'h20, 32'h0, MSK_W, 1'b0, "lw_20_unchanged", d);
    n_tests++;
    if (d !== 32'h11AA3344) begin n_fail++; $display("FAIL mis_unchanged got %h want 11aa3344", d); end
    go_idle();
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] d;
    int wes;
    access(1'b0, 1'b1, 32'h20, 32'h11223344, MSK_W, 1'b0, "sw_20_pre", d);
    go_idle();
    wes = 0;
    if (!BE_BUILD) begin
      @(posedge clk); #1;
      req_wr = 1'b1; req_addr = 32'h22; req_wdata = 32'hAA; req_mask = MSK_B;
      repeat (2) @(negedge clk);
      n_tests++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL rmw_rd_stall got %0b want 1", stall); end
      #1; rst = 1'b1; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_mask = MSK_W;
      repeat (3) begin @(negedge clk); if (ram_we) wes++; end
      @(posedge clk); #1; rst = 1'b0;
      repeat (3) begin @(negedge clk); if (ram_we) wes++; end
      n_tests++;
      if (wes != 0) begin n_fail++; $display("FAIL rmw_abort_writes got %0d want 0", wes); end
      access(1'b1, 1'b0, 32'h20, 32'h0, MSK_W, 1'b0, "lw_20_after_abort", d);
      n_tests++;
      if (d !== 32'h11223344) begin n_fail++; $display("FAIL rmw_abort_word got %h want 11223344", d); end
      go_idle();
    end
    @(posedge clk); #1;
    req_rd = 1'b1; req_addr = 32'h20; req_mask = MSK_W;
    @(negedge clk);
    #1; rst = 1'b1; req_rd = 1'b0; req_addr = '0;
    @(negedge clk);
    n_tests++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL load_drop rd_valid got %0b want 0", rd_valid); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rd_valid !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL load_drop_after got valid=%0b stall=%0b want 0/0", rd_valid, stall);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    access(1'b0, 1'b1, 32'h20, 32'h0, MSK_W, 1'b0, "b2b_sw0", d);
    access(1'b0, 1'b1, 32'h20, 32'hBB, MSK_B, 1'b0, "b2b_sb20", d);
    access(1'b0, 1'b1, 32'h21, 32'hCC, MSK_B, 1'b0, "b2b_sb21", d);
    access(1'b1, 1'b0, 32'h20, 32'h0, MSK_W, 1'b0, "b2b_lw20", d);
    n_tests++;
    if (d !== 32'h0000CCBB) begin n_fail++; $display("FAIL b2b_word got %h want 0000ccbb", d); end
    go_idle();
  endtask

  task automatic test_random(input int n);
    logic [31:0] a, wd, d;
    logic [`MASK_WIDTH-1:0] m;
    logic rd, wr, u;
    int sel, p;
    for (int k = 0; k < n; k++) begin
      sel = int'($urandom_range(0, 9));
      rd = (sel < 4) || (sel == 9);
      wr = (sel >= 4);
      p  = int'($urandom_range(0, 15));
      m  = (p == 15) ? 2'b11 : (p % 3 == 0) ? MSK_B : (p % 3 == 1) ? MSK_H : MSK_W;
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 8) a = (m == MSK_H) ? (a & 32'hFE) : (m == MSK_W) ? (a & 32'hFC) : a;
      wd = $urandom;
      u  = 1'($urandom_range(0, 1));
      access(rd, wr, a, wd, m, u, "random", d);
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();
  endtask

  task automatic test_sweep();
    logic [31:0] d;
    for (int w = 0; w < 64; w++) access(1'b1, 1'b0, 32'(w * 4), 32'h0, MSK_W, 1'b0, "sweep_lw", d);
    go_idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    test_reset();
    init_mem();
    test_word();
    test_byte_rmw();
    test_half_rmw();
    test_misalign();
    test_reset_mid_op();
    test_back_to_back();
    test_random(300);
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
